// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one or two stop bits.
// Frame data, format and prescale are captured at accept, so inputs may change freely mid-frame.
//   state    | meaning
//   S_IDLE   | line high, waiting for Data_Valid
//   S_START  | start bit (low)
//   S_DATA   | data bits, r_idx selects the bit
//   S_PARITY | parity bit
//   S_STOP   | stop bit(s), r_stop_sel marks the second one
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_stop_sel;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stop2;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [PRESCALE_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [IDX_W-1:0]      w_idx_inc;
    logic                  w_stop_sel_nxt;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_capture;
    logic                  w_bit_end;
    logic [PRESCALE_W-1:0] w_presc_in;

    assign w_presc_in = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_idx_inc      = r_idx + IDX_W'(1);
        w_stop_sel_nxt = r_stop_sel;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_capture      = 1'b0;
        // <= rather than == so a corrupted zero count still terminates the bit
        w_bit_end      = (r_cnt <= PRESCALE_W'(1));
        if (r_state != S_IDLE && !w_bit_end) begin
            w_cnt_nxt = r_cnt - PRESCALE_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (Data_Valid) begin
                    w_capture      = 1'b1;
                    w_state_nxt    = S_START;
                    w_cnt_nxt      = w_presc_in;
                    w_idx_nxt      = '0;
                    w_stop_sel_nxt = 1'b0;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = r_presc;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = r_data[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = r_presc;
                    if (r_idx == LAST_IDX) begin
                        if (r_par_en) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = (^r_data) ^ r_par_typ;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_tx_nxt  = r_data[w_idx_inc];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = r_presc;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_sel) begin
                        w_stop_sel_nxt = 1'b1;
                        w_cnt_nxt      = r_presc;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_sel <= 1'b0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_presc    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_stop_sel <= w_stop_sel_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (w_capture) begin
                r_data    <= P_DATA;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_stop2   <= STOP2;
                r_presc   <= w_presc_in;
            end
        end
    end

    assign TX_OUT  = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table vectors, hand sequences and random frames
// checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] p_data;
    logic       dv, pe, pt, s2;
    logic [7:0] presc;
    logic       tx_out, busy, tx_done;

    logic [4:0] p_data5;
    logic       dv5, pe5, pt5, s25;
    logic [7:0] presc5;
    logic       tx5, busy5, done5;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];
    int busy_cnt;

    uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut8 (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv), .PAR_EN(pe),
        .PAR_TYP(pt), .STOP2(s2), .PRESCALE(presc), .TX_OUT(tx_out), .busy(busy),
        .tx_done(tx_done)
    );

    uart_tx_frame #(.DATA_WIDTH(5), .PRESCALE_W(8)) dut5 (
        .CLK(clk), .RST(rst), .P_DATA(p_data5), .Data_Valid(dv5), .PAR_EN(pe5),
        .PAR_TYP(pt5), .STOP2(s25), .PRESCALE(presc5), .TX_OUT(tx5), .busy(busy5),
        .tx_done(done5)
    );

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        s2;
        logic [7:0]  ps;
        int          nbits;
        logic [11:0] bits;     // bit i = i-th serial bit of the frame
        int          exp_len;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame as a list of serial bits, each stretched to the bit period.
    task automatic build_model(input logic [7:0] d, input logic fpe, input logic fpt,
                               input logic fs2, input logic [7:0] fps);
        bit bits[$];
        int p;
        bits.delete();
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (fpe) bits.push_back((^d) ^ fpt);
        bits.push_back(1'b1);
        if (fs2) bits.push_back(1'b1);
        p = (fps == 0) ? 1 : int'(fps);
        exp_q.delete();
        foreach (bits[b]) for (int r = 0; r < p; r++) exp_q.push_back(bits[b]);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic fpe, input logic fpt,
                             input logic fs2, input logic [7:0] fps,
                             input bit drive, input bit hold, input bit poke);
        if (drive) begin
            @(negedge clk);
            p_data = d; pe = fpe; pt = fpt; s2 = fs2; presc = fps; dv = 1'b1;
        end
        busy_cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            chk("tx_bit", tx_out, exp_q[i]);
            chk("busy_in_frame", busy, 1);
            chk("done_in_frame", tx_done, 0);
            if (!hold) begin
                if (i == 0) begin
                    dv = 1'b0; p_data = ~d; presc = 8'd7; pe = ~fpe; pt = ~fpt; s2 = ~fs2;
                end
                if (poke && i == 2) begin dv = 1'b1; p_data = 8'h3C; end
                if (poke && i == 3) dv = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_pulse", tx_done, 1);
        chk("busy_end", busy, 0);
        chk("tx_idle", tx_out, 1);
        if (!hold) begin
            @(negedge clk);
            chk("done_once", tx_done, 0);
            chk("busy_idle", busy, 0);
            chk("tx_idle2", tx_out, 1);
        end
    endtask

    initial begin
        logic [7:0] w5;
        logic [7:0] rd;
        logic       rpe, rpt, rs2;
        logic [7:0] rps;
        int         p;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 10, 12'b001101001010, 10};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'd1, 11, 12'b010101001010, 11};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'd1, 11, 12'b011101001010, 11};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 8'd4, 12, 12'b111000000010, 48};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'd0, 10, 12'b001001111000, 10};

        rst = 1'b1; dv = 1'b0; p_data = '0; pe = 0; pt = 0; s2 = 0; presc = 8'd1;
        dv5 = 1'b0; p_data5 = '0; pe5 = 0; pt5 = 0; s25 = 0; presc5 = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_tx5", tx5, 1);
        chk("rst_busy5", busy5, 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            exp_q.delete();
            p = (vecs[v].ps == 0) ? 1 : int'(vecs[v].ps);
            for (int b = 0; b < vecs[v].nbits; b++)
                for (int r = 0; r < p; r++) exp_q.push_back(vecs[v].bits[b]);
            run_frame(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].s2, vecs[v].ps,
                      1'b1, 1'b0, (v == 0));
            chk("frame_len", busy_cnt, vecs[v].exp_len);
        end

        // Back-to-back: Data_Valid held high, next frame one idle cycle after tx_done
        build_model(8'hC3, 1'b0, 1'b0, 1'b0, 8'd1);
        run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0);
        run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 3 at prescale 2, with Data_Valid on the reset edge
        @(negedge clk);
        p_data = 8'h55; pe = 0; pt = 0; s2 = 0; presc = 8'd2; dv = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) dv = 1'b0;
        end
        chk("mid_bit3", tx_out, 0);
        rst = 1'b1; dv = 1'b1; p_data = 8'hFF;
        @(negedge clk);
        chk("rst_mid_tx", tx_out, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", tx_done, 0);
        rst = 1'b0; dv = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", tx_done, 0);
        chk("post_rst_tx", tx_out, 1);
        build_model(8'h55, 1'b0, 1'b0, 1'b0, 8'd2);
        run_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        chk("frame_len_55", busy_cnt, 20);

        // Width-5 variant: 10011, even parity, prescale 0
        w5 = 8'b11100110;
        @(negedge clk);
        p_data5 = 5'b10011; pe5 = 1'b1; pt5 = 1'b0; presc5 = 8'd0; dv5 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) dv5 = 1'b0;
            chk("w5_tx", tx5, w5[i]);
            chk("w5_busy", busy5, 1);
        end
        @(negedge clk);
        chk("w5_done", done5, 1);
        chk("w5_busy_end", busy5, 0);

        for (int k = 0; k < 20; k++) begin
            rd  = 8'($urandom);
            rpe = 1'($urandom_range(0, 1));
            rpt = 1'($urandom_range(0, 1));
            rs2 = 1'($urandom_range(0, 1));
            rps = 8'($urandom_range(0, 5));
            build_model(rd, rpe, rpt, rs2, rps);
            run_frame(rd, rpe, rpt, rs2, rps, 1'b1, 1'b0, (k % 4 == 0));
            chk("rand_len", busy_cnt, exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
